// File: rtl/ram_scan_reader.sv
// Streams a contiguous RAM window out on a valid/ready port.
// Reads are issued only when the output FIFO has room for every read still in flight.
//   state   | meaning
//   S_IDLE  | waiting for start; latches base/length
//   S_RUN   | issuing one RAM read per cycle while credit allows
//   S_DRAIN | all reads issued; waiting for the consumer to take the rest
//   S_DONE  | one-cycle completion pulse
module ram_scan_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_length,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_WIDTH-1:0]    o_out_data,
  output logic                     o_out_last
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [AW-1:0]       r_base;
  logic [AW:0]         r_len;
  logic [AW:0]         r_issued;
  logic [AW:0]         r_delivered;
  logic [AW-1:0]       r_ram_addr;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_vld_sr;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_inflight;
  logic [CW:0]   w_credit;
  logic          w_issue;
  logic [AW:0]   w_deliv_next;
  logic [AW:0]   w_last_idx;

  assign w_valid      = (r_count != '0);
  assign w_push       = r_vld_sr[1];
  assign w_pop        = w_valid && i_out_ready;
  assign w_inflight   = {1'b0, r_vld_sr[0]} + {1'b0, r_vld_sr[1]};
  // Conservative credit: a pop in the same cycle is not counted as free space.
  assign w_credit     = {1'b0, r_count} + {{(CW-1){1'b0}}, w_inflight};
  assign w_issue      = (r_state == S_RUN) && (r_issued < r_len) &&
                        (w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_deliv_next = r_delivered + (AW+1)'(w_pop);
  assign w_last_idx   = r_len - (AW+1)'(1);

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ram_addr  = r_ram_addr;
  assign o_out_valid = w_valid;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_out_last  = w_valid && (r_delivered == w_last_idx);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_ram_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vld_sr    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_busy   <= (r_state == S_RUN) || (r_state == S_DRAIN);
      r_vld_sr <= {r_vld_sr[0], w_issue};
      if (w_pop) r_delivered <= w_deliv_next;
      if (w_issue) begin
        r_ram_addr <= r_base + r_issued[AW-1:0];
        r_issued   <= r_issued + (AW+1)'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base      <= i_base_addr;
            r_len       <= i_length;
            r_issued    <= '0;
            r_delivered <= '0;
            // An empty job passes through DRAIN so done lands one cycle later, like busy.
            r_state     <= (i_length != '0) ? S_RUN : S_DRAIN;
          end
        end
        S_RUN: begin
          if (w_issue && ((r_issued + (AW+1)'(1)) == r_len)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_deliv_next == r_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_ram_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a RAM model and an in-order word scoreboard.
module tb_ram_scan_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] mem [4096];
  logic [32:0] sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          max_cnt = 0;

  logic        prev_v;
  logic        prev_r;
  logic [31:0] prev_d;
  logic        prev_l;

  ram_scan_reader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .o_busy(busy), .o_done(done), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfer monitor: scoreboard pops, hold-during-stall checks, FIFO level tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_d);
        chk("hold_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        chk("sb_has_word", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("word_data", out_data, e[31:0]);
          chk("word_last", out_last, e[32]);
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  task automatic start_job(input logic [11:0] b, input logic [12:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = b + i[11:0];
      d = {20'h0, a} + 32'h100;
      sb.push_back({(i == int'(n) - 1), d});
    end
    base_addr = b;
    length    = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int mode, output int cyc_done,
                                output int n_done);
    cyc_done = -1;
    n_done   = 0;
    for (int c = 0; c < budget; c++) begin
      if (mode == 0) out_ready = 1'b1;
      else           out_ready = (c >= 4 && c < 14) ? 1'b0 : c[0];
      step();
      if (done) begin
        n_done++;
        if (cyc_done < 0) cyc_done = c;
      end
      if (cyc_done >= 0 && c >= cyc_done + 2) break;
    end
    out_ready = 1'b1;
    chk("done_seen", cyc_done >= 0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nd;
    for (int a = 0; a < 4096; a++) mem[a] = a + 32'h100;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0; length = '0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ram_addr", ram_addr, 12'h000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    step();

    // base 0x010, length 5, consumer always ready: latency and no-bubble timing
    start_job(12'h010, 13'd5);
    chk("t1_busy_k", busy, 1'b0);
    step();
    chk("t1_busy_k1", busy, 1'b1);
    chk("t1_addr_k1", ram_addr, 12'h010);
    step();
    chk("t1_valid_k2", out_valid, 1'b0);
    step();
    chk("t1_valid_k3", out_valid, 1'b1);
    chk("t1_data_k3", out_data, 32'h110);
    run_until_done(100, 0, cyc, nd);
    chk("t1_done_latency", cyc, 4);
    chk("t1_done_count", nd, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_idle_busy", busy, 1'b0);

    // Address window wrapping past the top of RAM
    start_job(12'hFFE, 13'd4);
    step();
    chk("t2_addr_k1", ram_addr, 12'hFFE);
    step(); step();
    chk("t2_addr_k3", ram_addr, 12'h000);
    run_until_done(100, 0, cyc, nd);
    chk("t2_done_count", nd, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Zero-length job
    start_job(12'h055, 13'd0);
    chk("t3_done_k", done, 1'b0);
    chk("t3_valid_k", out_valid, 1'b0);
    step();
    chk("t3_done_k1", done, 1'b1);
    chk("t3_busy_k1", busy, 1'b1);
    chk("t3_valid_k1", out_valid, 1'b0);
    step();
    chk("t3_done_k2", done, 1'b0);
    chk("t3_busy_k2", busy, 1'b0);
    chk("t3_valid_k2", out_valid, 1'b0);

    // 16 words with toggling ready and a 10-cycle stall
    max_cnt = 0;
    start_job(12'h020, 13'd16);
    run_until_done(200, 1, cyc, nd);
    chk("t4_done_count", nd, 1);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_fifo_max_le4", max_cnt <= 4, 1'b1);
    chk("t4_fifo_reached_full", max_cnt, 4);

    // A second start while busy must be ignored
    start_job(12'h100, 13'd6);
    step();
    base_addr = 12'h300; length = 13'd3; start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(100, 0, cyc, nd);
    chk("t5_done_count", nd, 1);
    chk("t5_sb_empty", sb.size(), 0);
    step(); step(); step();
    chk("t5_after_busy", busy, 1'b0);
    chk("t5_after_valid", out_valid, 1'b0);

    // Reset for one cycle mid-job while the FIFO is backed up
    out_ready = 1'b0;
    start_job(12'h200, 13'd8);
    for (int i = 0; i < 6; i++) step();
    chk("t6_stalled_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_ram_addr", ram_addr, 12'h000);
    chk("t6_rst_out_valid", out_valid, 1'b0);
    chk("t6_rst_out_data", out_data, 32'h0);
    chk("t6_rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || out_valid) nd++;
    end
    chk("t6_quiet_after_rst", nd, 0);
    start_job(12'h000, 13'd3);
    run_until_done(100, 0, cyc, nd);
    chk("t6_fresh_done_count", nd, 1);
    chk("t6_fresh_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
